// File: rtl/axi4_lite_cmd_master_if.sv
// AXI4-Lite bus bundle shared by the command master and a register slave.
interface ifc_axi4_lite #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32
);
    logic [AXI_ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]                  awprot;
    logic                        awvalid;
    logic                        awready;
    logic [AXI_DATA_WIDTH-1:0]   wdata;
    logic [AXI_DATA_WIDTH/8-1:0] wstrb;
    logic                        wvalid;
    logic                        wready;
    logic [1:0]                  bresp;
    logic                        bvalid;
    logic                        bready;
    logic [AXI_ADDR_WIDTH-1:0]   araddr;
    logic [2:0]                  arprot;
    logic                        arvalid;
    logic                        arready;
    logic [AXI_DATA_WIDTH-1:0]   rdata;
    logic [1:0]                  rresp;
    logic                        rvalid;
    logic                        rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready
    );

    modport slave (
        input  awaddr, awprot, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input  araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/axi4_lite_cmd_master.sv
// Single-outstanding AXI4-Lite master: turns one command into one AXI transaction
// and returns its response, with an optional bus-wait timeout for debug use.
module axi4_lite_cmd_master #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                        clk,
    input  logic                        rst_n,
    ifc_axi4_lite.master                if_axi,
    input  logic                        i_cmd_valid,
    output logic                        o_cmd_ready,
    input  logic                        i_cmd_write,
    input  logic [AXI_ADDR_WIDTH-1:0]   i_cmd_addr,
    input  logic [AXI_DATA_WIDTH-1:0]   i_cmd_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] i_cmd_wstrb,
    output logic                        o_rsp_valid,
    input  logic                        i_rsp_ready,
    output logic [AXI_DATA_WIDTH-1:0]   o_rsp_rdata,
    output logic [1:0]                  o_rsp_resp,
    output logic                        o_rsp_timeout
);
    localparam int STRB_W = AXI_DATA_WIDTH / 8;
    localparam int CNT_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT =
        (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4,
        RSP     = 3'd5
    } state_t;

    state_t                    state;
    logic                      awvalid_q;
    logic                      wvalid_q;
    logic                      bready_q;
    logic                      arvalid_q;
    logic                      rready_q;
    logic                      rsp_valid_q;
    logic                      rsp_timeout_q;
    logic [AXI_DATA_WIDTH-1:0] rsp_rdata_q;
    logic [1:0]                rsp_resp_q;
    logic [CNT_W-1:0]          wait_cnt;

    logic [AXI_ADDR_WIDTH-1:0] addr_q;
    logic [AXI_DATA_WIDTH-1:0] wdata_q;
    logic [STRB_W-1:0]         wstrb_q;

    logic cmd_accept;
    logic limit_hit;
    logic aw_hs;
    logic w_hs;
    logic aw_done;
    logic w_done;

    assign cmd_accept = (state == IDLE) && i_cmd_valid;
    assign limit_hit  = (TIMEOUT_CYCLES != 0) && (wait_cnt == CNT_LIMIT);
    assign aw_hs      = awvalid_q && if_axi.awready;
    assign w_hs       = wvalid_q && if_axi.wready;
    // A channel counts as done once its valid has dropped or it handshakes now.
    assign aw_done    = !awvalid_q || if_axi.awready;
    assign w_done     = !wvalid_q || if_axi.wready;

    // Command payload is only sampled at acceptance, so it stays stable while valid.
    always_ff @(posedge clk) begin
        if (cmd_accept) begin
            addr_q  <= i_cmd_addr;
            wdata_q <= i_cmd_wdata;
            wstrb_q <= i_cmd_wstrb;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            bready_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= 2'b00;
            wait_cnt      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (i_cmd_valid) begin
                        wait_cnt <= '0;
                        if (i_cmd_write) begin
                            state     <= WR_REQ;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                        end else begin
                            state     <= RD_REQ;
                            arvalid_q <= 1'b1;
                        end
                    end
                end

                WR_REQ: begin
                    wait_cnt <= wait_cnt + CNT_W'(1);
                    if (limit_hit) begin
                        state         <= RSP;
                        awvalid_q     <= 1'b0;
                        wvalid_q      <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                        rsp_resp_q    <= 2'b10;
                        rsp_rdata_q   <= '0;
                    end else begin
                        if (aw_hs) awvalid_q <= 1'b0;
                        if (w_hs)  wvalid_q  <= 1'b0;
                        if (aw_done && w_done) begin
                            state    <= WR_RESP;
                            bready_q <= 1'b1;
                        end
                    end
                end

                WR_RESP: begin
                    wait_cnt <= wait_cnt + CNT_W'(1);
                    // A B beat on the limit cycle still completes normally.
                    if (if_axi.bvalid) begin
                        state         <= RSP;
                        bready_q      <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_timeout_q <= 1'b0;
                        rsp_resp_q    <= if_axi.bresp;
                        rsp_rdata_q   <= '0;
                    end else if (limit_hit) begin
                        state         <= RSP;
                        bready_q      <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                        rsp_resp_q    <= 2'b10;
                        rsp_rdata_q   <= '0;
                    end
                end

                RD_REQ: begin
                    wait_cnt <= wait_cnt + CNT_W'(1);
                    if (limit_hit) begin
                        state         <= RSP;
                        arvalid_q     <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                        rsp_resp_q    <= 2'b10;
                        rsp_rdata_q   <= '0;
                    end else if (if_axi.arready) begin
                        state     <= RD_RESP;
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                    end
                end

                RD_RESP: begin
                    wait_cnt <= wait_cnt + CNT_W'(1);
                    if (if_axi.rvalid) begin
                        state         <= RSP;
                        rready_q      <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_timeout_q <= 1'b0;
                        rsp_resp_q    <= if_axi.rresp;
                        rsp_rdata_q   <= if_axi.rdata;
                    end else if (limit_hit) begin
                        state         <= RSP;
                        rready_q      <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                        rsp_resp_q    <= 2'b10;
                        rsp_rdata_q   <= '0;
                    end
                end

                RSP: begin
                    if (i_rsp_ready) begin
                        state         <= IDLE;
                        rsp_valid_q   <= 1'b0;
                        rsp_timeout_q <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign o_cmd_ready   = (state == IDLE);
    assign o_rsp_valid   = rsp_valid_q;
    assign o_rsp_timeout = rsp_timeout_q;
    assign o_rsp_rdata   = rsp_rdata_q;
    assign o_rsp_resp    = rsp_resp_q;

    assign if_axi.awaddr  = addr_q;
    assign if_axi.awprot  = 3'b000;
    assign if_axi.awvalid = awvalid_q;
    assign if_axi.wdata   = wdata_q;
    assign if_axi.wstrb   = wstrb_q;
    assign if_axi.wvalid  = wvalid_q;
    assign if_axi.bready  = bready_q;
    assign if_axi.araddr  = addr_q;
    assign if_axi.arprot  = 3'b000;
    assign if_axi.arvalid = arvalid_q;
    assign if_axi.rready  = rready_q;
endmodule

// File: tb/tb_axi4_lite_cmd_master.sv
// Bench for axi4_lite_cmd_master: directed steps plus random traffic against a
// latency-configurable slave stub and a byte-level reference memory.
`timescale 1ns/1ps
module tb_axi4_lite_cmd_master;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ifc_axi4_lite #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) axi ();

    logic        cmd_valid = 1'b0, cmd_write = 1'b0, rsp_ready = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        cmd_ready, rsp_valid, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;

    axi4_lite_cmd_master #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .if_axi(axi),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_write(cmd_write),
        .i_cmd_addr(cmd_addr), .i_cmd_wdata(cmd_wdata), .i_cmd_wstrb(cmd_wstrb),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_rdata(rsp_rdata),
        .o_rsp_resp(rsp_resp), .o_rsp_timeout(rsp_timeout)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic fail(input string tag);
        n_bad++;
        $error("FAIL %s", tag);
    endtask

    // Slave stub: ready after N waiting cycles, B/R beats after N cycles; 0x00-0x3F is RAM, above is SLVERR.
    int   aw_lat = 0, w_lat = 0, ar_lat = 0, b_lat = 0, r_lat = 0;
    logic ar_block = 1'b0, stray_r = 1'b0;
    int   aw_wait, w_wait, ar_wait, b_cnt, r_cnt;
    logic aw_got, w_got, bpend, rpend;
    logic [31:0] aw_addr_s, w_data_s, r_data_s;
    logic [3:0]  w_strb_s;
    logic [1:0]  b_resp_s, r_resp_s;
    logic [31:0] mem [16];

    initial for (int i = 0; i < 16; i++) mem[i] = '0;

    assign axi.awready = axi.awvalid && (aw_wait >= aw_lat);
    assign axi.wready  = axi.wvalid && (w_wait >= w_lat);
    assign axi.arready = axi.arvalid && !ar_block && (ar_wait >= ar_lat);
    assign axi.bvalid  = bpend && (b_cnt == 0);
    assign axi.bresp   = b_resp_s;
    assign axi.rvalid  = (rpend && (r_cnt == 0)) || stray_r;
    assign axi.rdata   = r_data_s;
    assign axi.rresp   = r_resp_s;

    wire        aw_done = aw_got || (axi.awvalid && axi.awready);
    wire        w_done  = w_got || (axi.wvalid && axi.wready);
    wire [31:0] wr_addr = aw_got ? aw_addr_s : axi.awaddr;
    wire [31:0] wr_data = w_got ? w_data_s : axi.wdata;
    wire [3:0]  wr_strb = w_got ? w_strb_s : axi.wstrb;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_wait <= 0; w_wait <= 0; ar_wait <= 0; b_cnt <= 0; r_cnt <= 0;
            aw_got <= 1'b0; w_got <= 1'b0; bpend <= 1'b0; rpend <= 1'b0;
            aw_addr_s <= '0; w_data_s <= '0; w_strb_s <= '0; r_data_s <= '0;
            b_resp_s <= 2'b00; r_resp_s <= 2'b00;
        end else begin
            aw_wait <= (axi.awvalid && !axi.awready) ? aw_wait + 1 : 0;
            w_wait  <= (axi.wvalid && !axi.wready) ? w_wait + 1 : 0;
            ar_wait <= (axi.arvalid && !axi.arready) ? ar_wait + 1 : 0;
            if (axi.awvalid && axi.awready) begin aw_got <= 1'b1; aw_addr_s <= axi.awaddr; end
            if (axi.wvalid && axi.wready) begin w_got <= 1'b1; w_data_s <= axi.wdata; w_strb_s <= axi.wstrb; end
            if (aw_done && w_done && !bpend) begin
                aw_got <= 1'b0; w_got <= 1'b0; bpend <= 1'b1; b_cnt <= b_lat;
                if (wr_addr < 32'h40) begin
                    for (int i = 0; i < 4; i++)
                        if (wr_strb[i]) mem[wr_addr[5:2]][8*i +: 8] <= wr_data[8*i +: 8];
                    b_resp_s <= 2'b00;
                end else begin
                    b_resp_s <= 2'b10;
                end
            end else if (bpend && b_cnt != 0) begin
                b_cnt <= b_cnt - 1;
            end
            if (axi.bvalid && axi.bready) bpend <= 1'b0;
            if (axi.arvalid && axi.arready) begin
                rpend <= 1'b1; r_cnt <= r_lat;
                r_data_s <= (axi.araddr < 32'h40) ? mem[axi.araddr[5:2]] : 32'h0;
                r_resp_s <= (axi.araddr < 32'h40) ? 2'b00 : 2'b10;
            end else if (rpend && r_cnt != 0) begin
                r_cnt <= r_cnt - 1;
            end
            if (axi.rvalid && axi.rready) rpend <= 1'b0;
        end
    end

    // Bus monitor: beat and valid-cycle counts plus a sticky protocol-stability flag.
    logic clr_mon = 1'b0;
    int   aw_beats, w_beats, ar_beats, b_beats, r_beats, aw_cyc, w_cyc, ar_cyc;
    logic stab_err, p_aw, p_w, p_ar;
    logic [31:0] p_awaddr, p_wdata, p_araddr;
    logic [3:0]  p_wstrb;

    always @(posedge clk) begin
        if (clr_mon) begin
            aw_beats <= 0; w_beats <= 0; ar_beats <= 0; b_beats <= 0; r_beats <= 0;
            aw_cyc <= 0; w_cyc <= 0; ar_cyc <= 0; stab_err <= 1'b0;
            p_aw <= 1'b0; p_w <= 1'b0; p_ar <= 1'b0;
        end else begin
            if (axi.awvalid) aw_cyc <= aw_cyc + 1;
            if (axi.wvalid)  w_cyc  <= w_cyc + 1;
            if (axi.arvalid) ar_cyc <= ar_cyc + 1;
            if (axi.awvalid && axi.awready) aw_beats <= aw_beats + 1;
            if (axi.wvalid && axi.wready)   w_beats  <= w_beats + 1;
            if (axi.arvalid && axi.arready) ar_beats <= ar_beats + 1;
            if (axi.bvalid && axi.bready)   b_beats  <= b_beats + 1;
            if (axi.rvalid && axi.rready)   r_beats  <= r_beats + 1;
            if (p_aw && (!axi.awvalid || axi.awaddr !== p_awaddr)) stab_err <= 1'b1;
            if (p_w && (!axi.wvalid || axi.wdata !== p_wdata || axi.wstrb !== p_wstrb)) stab_err <= 1'b1;
            if (p_ar && (!axi.arvalid || axi.araddr !== p_araddr)) stab_err <= 1'b1;
            if ((axi.awvalid && axi.awprot !== 3'b000) || (axi.arvalid && axi.arprot !== 3'b000)) stab_err <= 1'b1;
            p_aw <= axi.awvalid && !axi.awready; p_awaddr <= axi.awaddr;
            p_w  <= axi.wvalid && !axi.wready;   p_wdata <= axi.wdata; p_wstrb <= axi.wstrb;
            p_ar <= axi.arvalid && !axi.arready; p_araddr <= axi.araddr;
        end
    end

    // Reference: byte-addressed memory, SLVERR above 0x3F.
    logic [7:0] ref_mem [int];

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        logic [31:0] d = '0;
        if (a < 32'h40)
            for (int i = 0; i < 4; i++)
                d[8*i +: 8] = ref_mem.exists(int'(a) + i) ? ref_mem[int'(a) + i] : 8'h00;
        return d;
    endfunction

    function automatic void ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        if (a < 32'h40)
            for (int i = 0; i < 4; i++)
                if (s[i]) ref_mem[int'(a) + i] = d[8*i +: 8];
    endfunction

    task automatic clear_mon();
        @(negedge clk); clr_mon = 1'b1;
        @(negedge clk); clr_mon = 1'b0;
    endtask

    task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb, input int hold,
                           output logic [31:0] rdata, output logic [1:0] resp, output logic tmo,
                           output int lat, output logic stable, output logic ready_after);
        int guard = 0;
        @(negedge clk);
        while (!cmd_ready && guard < 50) begin @(negedge clk); guard++; end
        n_cmp++; if (cmd_ready !== 1'b1) fail("cmd_ready_before_cmd");
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_wstrb = strb;
        @(negedge clk);
        // Junk command kept valid while busy; it must be ignored.
        cmd_write = ~wr; cmd_addr = $urandom; cmd_wdata = $urandom; cmd_wstrb = 4'($urandom);
        lat = 1;
        while (!rsp_valid && lat < 40) begin @(negedge clk); lat++; end
        rdata = rsp_rdata; resp = rsp_resp; tmo = rsp_timeout; stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_rdata !== rdata || rsp_resp !== resp || rsp_timeout !== tmo)
                stable = 1'b0;
        end
        rsp_ready = 1'b1; cmd_valid = 1'b0;
        @(negedge clk);
        rsp_ready = 1'b0;
        ready_after = cmd_ready && !rsp_valid;
    endtask

    logic [31:0] rd, a, d;
    logic [1:0]  rs;
    logic        tm, st, ra, wr, seen;
    logic [3:0]  s;
    int          lat, exp_lat, guard;

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready,
             rsp_valid, rsp_timeout, rsp_rdata, rsp_resp} !== 39'h0) fail("reset_outputs");
        n_cmp++; if (cmd_ready !== 1'b1) fail("reset_cmd_ready");
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (cmd_ready !== 1'b1) fail("post_reset_cmd_ready");

        // Zero-wait write then read-back
        clear_mon();
        run_txn(1'b1, 32'h08, 32'hDEADBEEF, 4'hF, 0, rd, rs, tm, lat, st, ra);
        ref_write(32'h08, 32'hDEADBEEF, 4'hF);
        n_cmp++; if (rs !== 2'b00) fail("wr0_resp");
        n_cmp++; if (tm !== 1'b0) fail("wr0_timeout");
        n_cmp++; if (lat !== 3) fail("wr0_latency");
        n_cmp++; if (aw_beats !== 1) fail("wr0_aw_beats");
        n_cmp++; if (w_beats !== 1) fail("wr0_w_beats");
        n_cmp++; if (b_beats !== 1) fail("wr0_b_beats");
        n_cmp++; if (ra !== 1'b1) fail("wr0_ready_after");
        clear_mon();
        run_txn(1'b0, 32'h08, 32'h0, 4'h0, 0, rd, rs, tm, lat, st, ra);
        n_cmp++; if (rd !== ref_read(32'h08)) fail("rd0_rdata");
        n_cmp++; if (rd !== 32'hDEADBEEF) fail("rd0_rdata_const");
        n_cmp++; if (rs !== 2'b00) fail("rd0_resp");
        n_cmp++; if (lat !== 3) fail("rd0_latency");
        n_cmp++; if (ar_beats !== 1) fail("rd0_ar_beats");

        // AW delayed, W immediate
        aw_lat = 4;
        clear_mon();
        run_txn(1'b1, 32'h0C, 32'hA5A5_1234, 4'b0101, 0, rd, rs, tm, lat, st, ra);
        ref_write(32'h0C, 32'hA5A5_1234, 4'b0101);
        n_cmp++; if (aw_cyc !== 5) fail("awdly_aw_cycles");
        n_cmp++; if (w_cyc !== 1) fail("awdly_w_cycles");
        n_cmp++; if (aw_beats !== 1) fail("awdly_aw_beats");
        n_cmp++; if (w_beats !== 1) fail("awdly_w_beats");
        n_cmp++; if (lat !== 7) fail("awdly_latency");
        n_cmp++; if (stab_err !== 1'b0) fail("awdly_stability");
        aw_lat = 0;

        // Response held off for 10 cycles
        clear_mon();
        run_txn(1'b0, 32'h0C, 32'h0, 4'h0, 10, rd, rs, tm, lat, st, ra);
        n_cmp++; if (rd !== ref_read(32'h0C)) fail("hold_rdata");
        n_cmp++; if (st !== 1'b1) fail("hold_stable");
        n_cmp++; if (ra !== 1'b1) fail("hold_ready_after");

        // Timeout on a stuck AR channel, then a stray R beat
        ar_block = 1'b1;
        clear_mon();
        run_txn(1'b0, 32'h04, 32'h0, 4'h0, 0, rd, rs, tm, lat, st, ra);
        n_cmp++; if (tm !== 1'b1) fail("tmo_flag");
        n_cmp++; if (rs !== 2'b10) fail("tmo_resp");
        n_cmp++; if (rd !== 32'h0) fail("tmo_rdata");
        n_cmp++; if (ar_cyc !== TO) fail("tmo_ar_cycles");
        n_cmp++; if (lat !== TO + 1) fail("tmo_latency");
        ar_block = 1'b0;
        @(negedge clk); stray_r = 1'b1;
        repeat (5) @(negedge clk);
        stray_r = 1'b0;
        n_cmp++; if (r_beats !== 0) fail("stray_r_rejected");
        clear_mon();
        run_txn(1'b0, 32'h08, 32'h0, 4'h0, 0, rd, rs, tm, lat, st, ra);
        n_cmp++; if (rd !== ref_read(32'h08)) fail("after_tmo_rdata");
        n_cmp++; if (r_beats !== 1) fail("after_tmo_r_beats");

        // Random traffic with random slave latencies
        for (int n = 0; n < 24; n++) begin
            aw_lat = $urandom_range(0, 3); w_lat = $urandom_range(0, 3); b_lat = $urandom_range(0, 3);
            ar_lat = $urandom_range(0, 3); r_lat = $urandom_range(0, 3);
            wr = 1'($urandom); a = 32'($urandom_range(0, 31)) * 4; d = $urandom; s = 4'($urandom);
            clear_mon();
            run_txn(wr, a, d, s, $urandom_range(0, 2), rd, rs, tm, lat, st, ra);
            if (wr) begin
                ref_write(a, d, s);
                exp_lat = 3 + ((aw_lat > w_lat) ? aw_lat : w_lat) + b_lat;
                n_cmp++; if (rd !== 32'h0) fail("rnd_wr_rdata_zero");
                n_cmp++;
                if ({aw_beats, w_beats, ar_beats} !== {32'd1, 32'd1, 32'd0}) fail("rnd_wr_beats");
            end else begin
                exp_lat = 3 + ar_lat + r_lat;
                n_cmp++; if (rd !== ref_read(a)) fail("rnd_rd_rdata");
                n_cmp++;
                if ({aw_beats, w_beats, ar_beats} !== {32'd0, 32'd0, 32'd1}) fail("rnd_rd_beats");
            end
            n_cmp++; if (rs !== ((a < 32'h40) ? 2'b00 : 2'b10)) fail("rnd_resp");
            n_cmp++; if (tm !== 1'b0) fail("rnd_timeout");
            n_cmp++; if (lat !== exp_lat) fail("rnd_latency");
            n_cmp++; if (stab_err !== 1'b0) fail("rnd_stability");
        end
        aw_lat = 0; w_lat = 0; b_lat = 0; ar_lat = 0; r_lat = 0;

        // Reset in WR_RESP aborts the transaction
        b_lat = 8;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h10; cmd_wdata = 32'h1234_5678; cmd_wstrb = 4'hF;
        @(negedge clk);
        cmd_valid = 1'b0;
        guard = 0;
        while (!axi.bready && guard < 20) begin @(negedge clk); guard++; end
        n_cmp++; if (axi.bready !== 1'b1) fail("rst_reached_wr_resp");
        ref_write(32'h10, 32'h1234_5678, 4'hF);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready,
             rsp_valid, rsp_timeout, rsp_rdata, rsp_resp} !== 39'h0) fail("rst_mid_outputs");
        @(negedge clk);
        rst_n = 1'b1;
        b_lat = 0;
        @(negedge clk);
        n_cmp++; if (cmd_ready !== 1'b1) fail("rst_release_cmd_ready");
        seen = 1'b0;
        repeat (4) begin @(negedge clk); if (rsp_valid) seen = 1'b1; end
        n_cmp++; if (seen !== 1'b0) fail("rst_no_response");
        clear_mon();
        run_txn(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, rs, tm, lat, st, ra);
        n_cmp++; if (rd !== ref_read(32'h10)) fail("rst_readback");
        n_cmp++; if (lat !== 3) fail("rst_readback_latency");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
